// File: rtl/mod3_residue_gen.sv
// Serial mod-3 residue generator: folds a W-bit operand into X mod 3, one base-4 digit per clock.
// Fault points on the accumulator and the residue output share the global fault_en_bus/fault_val scheme.
module mod3_residue_gen #(
    parameter int W       = 32,
    parameter int NG      = 128,
    parameter int GID_ACC = 0,
    parameter int GID_OUT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [NG-1:0] fault_en_bus,
    input  logic          fault_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_res,
    output logic [W-1:0]  out_data
);

    localparam int ND = W / 2;
    localparam int CW = $clog2(ND + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [W-1:0]  oper_q, oper_d;
    logic [1:0]    sum;
    logic [1:0]    res_raw;
    logic          unused_fault_bits;

    // Operands are reduced by value, so a stray 11 behaves as 0 rather than 3.
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, (a == 2'b11) ? 2'b00 : a} + {1'b0, (b == 2'b11) ? 2'b00 : b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    assign sum = mod3_add(acc_q, shift_q[1:0]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        oper_d  = oper_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    oper_d  = in_data;
                    shift_d = in_data;
                    acc_d   = 2'b00;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {sum[1], fault_en_bus[GID_ACC] ? fault_val : sum[0]};
                shift_d = shift_q >> 2;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(ND - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 2'b00;
            cnt_q   <= '0;
            shift_q <= '0;
            oper_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            oper_q  <= oper_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    // The residue is only presented while a result is held; output fault muxes act in every state.
    assign res_raw    = (state_q == DONE) ? acc_q : 2'b00;
    assign out_res[0] = fault_en_bus[GID_OUT]     ? fault_val : res_raw[0];
    assign out_res[1] = fault_en_bus[GID_OUT + 1] ? fault_val : res_raw[1];
    assign out_data   = oper_q;

    assign unused_fault_bits = ^fault_en_bus;

endmodule

// File: tb/tb_mod3_residue_gen.sv
// Directed bench for mod3_residue_gen: latency, residues, backpressure, async abort and fault points.
module tb_mod3_residue_gen;

    localparam int W       = 32;
    localparam int NG      = 128;
    localparam int GID_ACC = 0;
    localparam int GID_OUT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [NG-1:0] fault_en_bus = '0;
    logic          fault_val = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_res;
    logic [W-1:0]  out_data;

    int n_cmp = 0;
    int n_bad = 0;

    mod3_residue_gen #(.W(W), .NG(NG), .GID_ACC(GID_ACC), .GID_OUT(GID_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .fault_en_bus(fault_en_bus), .fault_val(fault_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Stimulus only: offer an operand, wait for the result, sample it, then transfer it.
    task automatic run_op(input logic [W-1:0] data, output logic [1:0] res,
                          output logic [W-1:0] dat, output bit tmo);
        tmo = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (i == 49) tmo = 1'b1;
        end
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
            if (i == 49) tmo = 1'b1;
        end
        res = out_res;
        dat = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_res !== 2'b00)   begin n_bad++; $display("FAIL reset_out_res got %b want 00", out_res); end
        n_cmp++; if (out_data !== '0)     begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_latency();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0007;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid got %b want 1", out_valid); end
        n_cmp++; if (out_res !== 2'b01) begin n_bad++; $display("FAIL lat_res got %b want 01", out_res); end
        n_cmp++; if (out_data !== 32'h7) begin n_bad++; $display("FAIL lat_data got %h want 00000007", out_data); end
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lat_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_drop got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_patterns();
        logic [W-1:0] vec [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_000B, 32'h8000_0000};
        logic [1:0]   exp [4] = '{2'b00, 2'b10, 2'b10, 2'b10};
        logic [1:0]   r;
        logic [W-1:0] d;
        bit           t;
        for (int i = 0; i < 4; i++) begin
            run_op(vec[i], r, d, t);
            n_cmp++; if (t)            begin n_bad++; $display("FAIL pat_timeout[%0d] got timeout want result", i); end
            n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL pat_res[%0d] got %b want %b", i, r, exp[i]); end
            n_cmp++; if (d !== vec[i]) begin n_bad++; $display("FAIL pat_data[%0d] got %h want %h", i, d, vec[i]); end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0004;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_data  = 32'hDEAD_BEEF;
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_res !== 2'b01 || out_data !== 32'h4 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d] got v=%b r=%b d=%h rdy=%b want v=1 r=01 d=00000004 rdy=0",
                         i, out_valid, out_res, out_data, in_ready);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_single got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic [1:0]   r;
        logic [W-1:0] d;
        bit           t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 2'b00 || out_data !== '0) begin
            n_bad++;
            $display("FAIL abort_async got rdy=%b v=%b r=%b d=%h want rdy=1 v=0 r=00 d=0",
                     in_ready, out_valid, out_res, out_data);
        end
        @(negedge clk) rst_n = 1'b1;
        run_op(32'h0000_0003, r, d, t);
        n_cmp++; if (t || r !== 2'b00 || d !== 32'h3) begin
            n_bad++; $display("FAIL abort_next got r=%b d=%h tmo=%b want r=00 d=00000003 tmo=0", r, d, t);
        end
    endtask

    task automatic test_faults();
        logic [1:0]   r;
        logic [W-1:0] d;
        bit           t;
        fault_en_bus[GID_OUT + 1] = 1'b1;
        fault_val = 1'b1;
        run_op(32'h0000_0001, r, d, t);
        n_cmp++; if (t || r !== 2'b11) begin n_bad++; $display("FAIL fault_out got r=%b tmo=%b want r=11", r, t); end
        n_cmp++; if (r === 2'b01) begin n_bad++; $display("FAIL fault_cmp got %b equal to golden 01 want differ", r); end
        fault_en_bus = '0;
        fault_en_bus[GID_ACC] = 1'b1;
        fault_val = 1'b0;
        run_op(32'h0000_0001, r, d, t);
        n_cmp++; if (t || r !== 2'b00) begin n_bad++; $display("FAIL fault_acc got r=%b tmo=%b want r=00", r, t); end
        fault_en_bus = '0;
        run_op(32'h0000_0001, r, d, t);
        n_cmp++; if (t || r !== 2'b01) begin n_bad++; $display("FAIL fault_clear got r=%b tmo=%b want r=01", r, t); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_backpressure();
        test_abort();
        test_faults();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
